booth_mul_sched: RTL and testbench
==================================

BOOTH_MUL_SCHED -- requirements
Module: booth_mul_sched

Interface
REQ-001 SHALL have parameter PARM_MANT, default 23, meaning mantissa width excluding hidden bit; operands are PARM_MANT+1 bits.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req0_valid_i, input, 1 bit: requester 0 offers an operand pair.
REQ-005 SHALL have port req0_ready_o, output, 1 bit: requester 0 is granted and its pair is accepted this cycle.
REQ-006 SHALL have ports req0_mant_a_i and req0_mant_b_i, input, PARM_MANT+1 bits each: unsigned {hidden, mantissa} operands for requester 0.
REQ-007 SHALL have ports req1_valid_i, req1_ready_o, req1_mant_a_i and req1_mant_b_i, identical to REQ-004..006, for requester 1.
REQ-008 SHALL have port res_valid_o, output, 1 bit: a product is available.
REQ-009 SHALL have port res_ready_i, input, 1 bit: the consumer takes the product.
REQ-010 SHALL have port res_prod_o, output, 2*PARM_MANT+2 bits: unsigned product A*B.
REQ-011 SHALL have port res_id_o, output, 1 bit: index of the requester that owns res_prod_o.
REQ-012 SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-014 In IDLE, ready SHALL be asserted combinationally to exactly one valid requester; with no valid requester, both readies SHALL be low; in CALC and DONE, both readies SHALL be low.
REQ-015 Arbitration SHALL be round-robin: if both requesters are valid, grant the one not recorded in last_grant; if only one is valid, grant it; last_grant updates only on an accept.
REQ-016 On accept (valid&ready), the block SHALL latch A, latch B padded as {2'b0, B, 1'b0}, latch the requester id, clear the accumulator and digit counter, and go to CALC; input changes after the accept SHALL have no effect.
REQ-017 CALC SHALL process one radix-4 Booth digit per cycle for NUM_PP=(PARM_MANT+3)/2 cycles (13 at default), using digit i = padded B bits [2i+2:2i].
REQ-018 Digit recoding SHALL be: 000/111 -> 0; 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A.
REQ-019 Each CALC cycle SHALL add the selected multiple, as an exact two's-complement value shifted left 2i, into an accumulator at least 2*PARM_MANT+4 bits wide.
REQ-020 After digit NUM_PP-1 is accumulated, the FSM SHALL enter DONE; res_prod_o SHALL be the low 2*PARM_MANT+2 accumulator bits, equal to A*B exactly.
REQ-021 Latency: for a handshake in cycle N, res_valid_o SHALL first be high in cycle N+NUM_PP+1 (N+14 at default).
REQ-022 In DONE, res_valid_o SHALL be high and res_prod_o and res_id_o SHALL hold stable until res_ready_i=1; the handshake cycle SHALL return the FSM to IDLE.
REQ-023 No new request SHALL be accepted in the same cycle as a result handshake; the minimum spacing between accepts is NUM_PP+2 cycles.
REQ-024 res_prod_o and res_id_o SHALL be 0 whenever res_valid_o=0.

Reset
REQ-025 While rst_i=1 at a clock edge: state SHALL go to IDLE, last_grant to 1 (requester 0 wins the first tie), and accumulator, counter and latched operands to 0.
REQ-026 After reset: res_valid_o=0, res_prod_o=0, res_id_o=0 and busy_o=0; readies follow REQ-014.
REQ-027 Reset in any state, including mid-CALC or DONE, SHALL discard the operation without producing a result.

Verification
REQ-028 After reset, req0 A=0xFFFFFF and B=0xFFFFFF, handshake in cycle N -> res_valid_o=1 in cycle N+14 with res_prod_o=0xFFFFFE000001 and res_id_o=0.
REQ-029 Both requesters held valid continuously -> accepts alternate 0,1,0,1 and each res_id_o matches its operands; A=0x800000, B=0x800000 -> 0x400000000000.
REQ-030 A=0x000001, B=0xAAAAAA (-1/-2 digits) -> res_prod_o=0x000000AAAAAA; A=0 with any B -> 0.
REQ-031 res_ready_i held low for 5 cycles in DONE -> res_valid_o, res_prod_o and res_id_o stay stable, both readies stay low, no accept occurs, and busy_o=1.
REQ-032 rst_i pulsed in the 6th CALC cycle -> next cycle busy_o=0 and res_valid_o=0, no result is produced, and the following operation is correct with full latency.

Source files
------------

// File: rtl/booth_mul_sched.sv
// Two-requester radix-4 Booth mantissa multiplier: round-robin arbitration in IDLE,
// one Booth digit per CALC cycle, result held in DONE until the consumer takes it.
module booth_mul_sched #(
  parameter int PARM_MANT = 23
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req0_valid_i,
  output logic                   req0_ready_o,
  input  logic [PARM_MANT:0]     req0_mant_a_i,
  input  logic [PARM_MANT:0]     req0_mant_b_i,
  input  logic                   req1_valid_i,
  output logic                   req1_ready_o,
  input  logic [PARM_MANT:0]     req1_mant_a_i,
  input  logic [PARM_MANT:0]     req1_mant_b_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [2*PARM_MANT+1:0] res_prod_o,
  output logic                   res_id_o,
  output logic                   busy_o
);

  localparam int W      = PARM_MANT + 1;
  localparam int P_W    = 2*PARM_MANT + 2;
  localparam int ACC_W  = 2*PARM_MANT + 4;
  localparam int PB_W   = PARM_MANT + 4;
  localparam int NUM_PP = (PARM_MANT + 3) / 2;
  localparam int CNT_W  = $clog2(NUM_PP + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t             state_q;
  logic               last_q;
  logic               id_q;
  logic [W-1:0]       a_q;
  logic [PB_W-1:0]    pb_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               gnt0;
  logic               gnt1;
  logic [2:0]         dig;
  logic [ACC_W-1:0]   a_ext;
  logic [ACC_W-1:0]   mult;
  logic [ACC_W-1:0]   acc_d;

  // Tie goes to whichever requester did not win the previous accept.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == S_IDLE) begin
      gnt0 = req0_valid_i && (!req1_valid_i || last_q);
      gnt1 = req1_valid_i && (!req0_valid_i || !last_q);
    end
  end

  always_comb begin
    dig   = 3'(pb_q >> {cnt_q, 1'b0});
    a_ext = ACC_W'(a_q);
    mult  = '0;
    case (dig)
      3'b001, 3'b010: mult = a_ext;
      3'b011:         mult = a_ext << 1;
      3'b100:         mult = -(a_ext << 1);
      3'b101, 3'b110: mult = -a_ext;
      default:        mult = '0;
    endcase
    acc_d = acc_q + (mult << {cnt_q, 1'b0});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      a_q     <= '0;
      pb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt0 || gnt1) begin
            a_q     <= gnt1 ? req1_mant_a_i : req0_mant_a_i;
            pb_q    <= {2'b00, (gnt1 ? req1_mant_b_i : req0_mant_b_i), 1'b0};
            id_q    <= gnt1;
            last_q  <= gnt1;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          if (cnt_q == CNT_W'(NUM_PP - 1)) begin
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (res_ready_i) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;
  assign res_valid_o  = (state_q == S_DONE);
  assign res_prod_o   = res_valid_o ? acc_q[P_W-1:0] : '0;
  assign res_id_o     = res_valid_o & id_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_booth_mul_sched.sv
// Self-checking bench for booth_mul_sched: directed vector table, arbitration
// scoreboard, DONE-hold and mid-CALC reset sequences, randomized products.
module tb_booth_mul_sched;

  localparam int M      = 23;
  localparam int NUM_PP = (M + 3) / 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, rdy0, rdy1;
  logic [23:0] a0, b0, a1, b1;
  logic        res_valid, res_ready, res_id, busy;
  logic [47:0] res_prod;

  int checks = 0;
  int errors = 0;

  booth_mul_sched #(.PARM_MANT(M)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req0_valid_i (v0),
    .req0_ready_o (rdy0),
    .req0_mant_a_i(a0),
    .req0_mant_b_i(b0),
    .req1_valid_i (v1),
    .req1_ready_o (rdy1),
    .req1_mant_a_i(a1),
    .req1_mant_b_i(b1),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_prod_o   (res_prod),
    .res_id_o     (res_id),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] prod;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [47:0] ref_mul(input logic [23:0] a, input logic [23:0] b);
    return 48'(a) * 48'(b);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int id);
    return (id == 1) ? rdy1 : rdy0;
  endfunction

  // Offer a pair on one requester, wait for its grant, leave after the accept edge.
  task automatic do_accept(input int id, input logic [23:0] a, input logic [23:0] b);
    int n;
    if (id == 1) begin v1 = 1'b1; a1 = a; b1 = b; end
    else         begin v0 = 1'b1; a0 = a; b0 = b; end
    #1;
    n = 0;
    while (!rdy(id) && n < 50) begin step(); #1; n++; end
    chk("grant_seen", 64'(rdy(id)), 64'd1);
    chk("other_ready_low", 64'(rdy(1 - id)), 64'd0);
    step();
    if (id == 1) begin v1 = 1'b0; a1 = 24'($urandom); b1 = 24'($urandom); end
    else         begin v0 = 1'b0; a0 = 24'($urandom); b0 = 24'($urandom); end
  endtask

  task automatic wait_result(input logic [47:0] exp, input int eid, input string name);
    int lat;
    #1;
    lat = 1;
    while (!res_valid && lat < 60) begin
      chk("calc_readies_low", 64'({rdy0, rdy1}), 64'd0);
      step(); #1; lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(NUM_PP + 1));
    chk({name, "_prod"}, 64'(res_prod), 64'(exp));
    chk({name, "_id"}, 64'(res_id), 64'(eid));
    chk({name, "_busy"}, 64'(busy), 64'd1);
  endtask

  task automatic finish_result();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    #1;
    chk("post_valid", 64'(res_valid), 64'd0);
    chk("post_prod_zero", 64'(res_prod), 64'd0);
    chk("post_id_zero", 64'(res_id), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
  endtask

  task automatic run_op(input int id, input logic [23:0] a, input logic [23:0] b,
                        input logic [47:0] exp, input string name);
    do_accept(id, a, b);
    wait_result(exp, id, name);
    finish_result();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] ra, rb;
    logic [47:0] q_prod[$];
    int          q_id[$];
    int          exp_next, accepts, results, last_acc, cyc, gid, sel;
    logic        acc_flag;

    tbl[0] = '{0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001};
    tbl[1] = '{0, 24'h800000, 24'h800000, 48'h400000000000};
    tbl[2] = '{1, 24'h000001, 24'hAAAAAA, 48'h000000AAAAAA};
    tbl[3] = '{0, 24'h000000, 24'h123456, 48'h000000000000};
    tbl[4] = '{1, 24'h000002, 24'h000003, 48'h000000000006};
    tbl[5] = '{0, 24'hFFFFFF, 24'h000001, 48'h000000FFFFFF};
    tbl[6] = '{1, 24'h800000, 24'hFFFFFF, 48'h7FFFFF800000};
    tbl[7] = '{0, 24'h555555, 24'h000000, 48'h000000000000};

    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; res_ready = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_prod", 64'(res_prod), 64'd0);
    chk("rst_id", 64'(res_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_readies", 64'({rdy0, rdy1}), 64'd0);
    step();

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].prod, $sformatf("vec%0d", i));
    end

    // Fresh reset so requester 0 wins the first tie.
    rst = 1'b1; step(); rst = 1'b0;
    res_ready = 1'b1;
    a0 = 24'h800000; b0 = 24'h800000;
    a1 = 24'($urandom); b1 = 24'($urandom);
    v0 = 1'b1; v1 = 1'b1;
    exp_next = 0; accepts = 0; results = 0; last_acc = -100; cyc = 0;
    #1;
    while (results < 4 && cyc < 200) begin
      acc_flag = 1'b0;
      gid = 0;
      if (rdy0 && rdy1) chk("both_ready", 64'd1, 64'd0);
      if (rdy0 || rdy1) begin
        gid = rdy1 ? 1 : 0;
        chk("rr_order", 64'(gid), 64'(exp_next));
        if (accepts > 0) chk("accept_spacing", 64'(cyc - last_acc >= NUM_PP + 2), 64'd1);
        q_prod.push_back(gid == 1 ? ref_mul(a1, b1) : ref_mul(a0, b0));
        q_id.push_back(gid);
        exp_next = 1 - gid;
        accepts++;
        last_acc = cyc;
        acc_flag = 1'b1;
      end
      if (res_valid) begin
        if (q_prod.size() == 0) begin
          chk("sb_unexpected_result", 64'd1, 64'd0);
        end else begin
          chk("sb_prod", 64'(res_prod), 64'(q_prod.pop_front()));
          chk("sb_id", 64'(res_id), 64'(q_id.pop_front()));
        end
        results++;
      end
      step();
      if (acc_flag) begin
        if (gid == 1) begin a1 = 24'($urandom); b1 = 24'($urandom); end
        else          begin a0 = 24'($urandom); b0 = 24'($urandom); end
      end
      cyc++;
      #1;
    end
    chk("sb_results", 64'(results), 64'd4);
    v0 = 1'b0; v1 = 1'b0; res_ready = 1'b0;
    // Drain anything accepted in the final loop cycle.
    repeat (NUM_PP + 3) step();
    res_ready = 1'b1; step(); res_ready = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;

    // Result held while the consumer stalls.
    do_accept(0, 24'h123456, 24'h654321);
    wait_result(ref_mul(24'h123456, 24'h654321), 0, "hold");
    for (int k = 0; k < 5; k++) begin
      v0 = 1'b1; v1 = 1'b1;
      a1 = 24'($urandom); b1 = 24'($urandom);
      #1;
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_prod", 64'(res_prod), 64'(ref_mul(24'h123456, 24'h654321)));
      chk("hold_id", 64'(res_id), 64'd0);
      chk("hold_readies", 64'({rdy0, rdy1}), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
      step();
    end
    v1 = 1'b0;
    res_ready = 1'b1;
    #1;
    chk("handshake_no_accept", 64'(rdy0), 64'd0);
    chk("handshake_valid", 64'(res_valid), 64'd1);
    v0 = 1'b0;
    step();
    res_ready = 1'b0;
    #1;
    chk("hold_released", 64'({res_valid, busy}), 64'd0);
    step();

    // Reset asserted during the sixth CALC cycle discards the operation.
    do_accept(1, 24'hABCDEF, 24'h13579B);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_valid", 64'(res_valid), 64'd0);
    sel = 0;
    for (int k = 0; k < 20; k++) begin
      if (res_valid) sel = 1;
      step();
    end
    chk("midrst_no_result", 64'(sel), 64'd0);
    v0 = 1'b1; v1 = 1'b1;
    #1;
    chk("midrst_tie_grant", 64'({rdy0, rdy1}), 64'b10);
    v0 = 1'b0; v1 = 1'b0;
    step();
    run_op(1, 24'hABCDEF, 24'h13579B, ref_mul(24'hABCDEF, 24'h13579B), "after_rst");

    for (int i = 0; i < 16; i++) begin
      sel = $urandom_range(0, 3);
      ra  = (sel == 0) ? 24'hFFFFFF : 24'($urandom);
      rb  = (sel == 1) ? 24'h800000 : 24'($urandom);
      gid = $urandom_range(0, 1);
      run_op(gid, ra, rb, ref_mul(ra, rb), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
